// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcodes, exception causes and the
// execute-side register payload with its reset/bubble value.
package decode_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ECAUSE_W = 4;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [ECAUSE_W-1:0] ECAUSE_NONE          = 4'd0;
    localparam logic [ECAUSE_W-1:0] ECAUSE_ILLEGAL_INSTR = 4'd2;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     instr;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     rdata1;
        logic [XLEN-1:0]     rdata2;
        logic [REG_AW-1:0]   waddr;
        logic                wren;
        logic                exception;
        logic [ECAUSE_W-1:0] ecause;
        logic [XLEN-1:0]     etval;
    } decode_reg_type;

    // Reset value; also used as the bubble inserted on stalls and kills
    localparam decode_reg_type init_decode_reg = '{
        valid:     1'b0,
        pc:        '0,
        instr:     NOP_INSTR,
        imm:       '0,
        rdata1:    '0,
        rdata2:    '0,
        waddr:     '0,
        wren:      1'b0,
        exception: 1'b0,
        ecause:    ECAUSE_NONE,
        etval:     '0
    };

    typedef struct packed {
        logic [XLEN-1:0]   imm;
        logic              use_rs1;
        logic              use_rs2;
        logic [REG_AW-1:0] waddr;
        logic              wren;
        logic              illegal;
        logic              is_jal;
    } decode_info_t;

endpackage

// File: rtl/decode_stage_if.sv
// Execute-side operand bus driven by the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic                q_valid;
    logic [XLEN-1:0]     q_pc;
    logic [XLEN-1:0]     q_instr;
    logic [XLEN-1:0]     q_imm;
    logic [XLEN-1:0]     q_rdata1;
    logic [XLEN-1:0]     q_rdata2;
    logic [REG_AW-1:0]   q_waddr;
    logic                q_wren;
    logic                q_exception;
    logic [ECAUSE_W-1:0] q_ecause;
    logic [XLEN-1:0]     q_etval;

    modport master (
        output q_valid, q_pc, q_instr, q_imm, q_rdata1, q_rdata2,
               q_waddr, q_wren, q_exception, q_ecause, q_etval
    );

    modport slave (
        input q_valid, q_pc, q_instr, q_imm, q_rdata1, q_rdata2,
              q_waddr, q_wren, q_exception, q_ecause, q_etval
    );

endinterface

// File: rtl/decode_stage_decoder.sv
// Pure combinational RV32I decode: immediate, source-use flags, destination
// and legality of one instruction word.
module decoder
    import decode_stage_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output decode_info_t    info
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   imm_j;
    logic              writes_rd;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Every base opcode ends in 2'b11, so compressed encodings fall to default
    always_comb begin
        info      = '0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                info.imm  = imm_u;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                info.imm    = imm_j;
                info.is_jal = 1'b1;
                writes_rd   = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                info.imm     = imm_i;
                info.use_rs1 = 1'b1;
                writes_rd    = 1'b1;
            end
            OPC_BRANCH: begin
                info.imm     = imm_b;
                info.use_rs1 = 1'b1;
                info.use_rs2 = 1'b1;
            end
            OPC_STORE: begin
                info.imm     = imm_s;
                info.use_rs1 = 1'b1;
                info.use_rs2 = 1'b1;
            end
            OPC_OP: begin
                info.use_rs1 = 1'b1;
                info.use_rs2 = 1'b1;
                writes_rd    = 1'b1;
            end
            OPC_MISC_MEM: begin
                info.imm = imm_i;
            end
            OPC_SYSTEM: begin
                info.imm  = imm_i;
                writes_rd = 1'b1;
            end
            default: begin
                info.illegal = 1'b1;
            end
        endcase
        info.waddr = writes_rd ? rd : '0;
        info.wren  = writes_rd && (rd != '0);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: registers decoded operands toward execute, resolves JAL
// redirects early and stalls fetch on load-use hazards or execute backpressure.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     f_pc,
    input  logic [XLEN-1:0]     f_instr,
    input  logic                e_stall,
    input  logic                e_clear,
    input  logic                e_load,
    input  logic [REG_AW-1:0]   e_waddr,
    input  logic [XLEN-1:0]     rf_rdata1,
    input  logic [XLEN-1:0]     rf_rdata2,
    output logic [REG_AW-1:0]   rf_raddr1,
    output logic [REG_AW-1:0]   rf_raddr2,
    output logic                d_stall,
    output logic                d_jump,
    output logic [XLEN-1:0]     d_address,
    decode_stage_if.master      q_bus
);

    decode_reg_type q_q;
    decode_reg_type q_d;
    decode_reg_type issue;
    logic           kill_q;
    logic           kill_d;
    decode_info_t   info;
    logic           hazard;

    assign rf_raddr1 = f_instr[19:15];
    assign rf_raddr2 = f_instr[24:20];

    decoder u_decoder (
        .instr (f_instr),
        .info  (info)
    );

    // Only sources the format actually reads can create a load-use hazard
    always_comb begin
        hazard = 1'b0;
        if (e_load && (e_waddr != '0)) begin
            hazard = (info.use_rs1 && (e_waddr == rf_raddr1)) ||
                     (info.use_rs2 && (e_waddr == rf_raddr2));
        end
    end

    always_comb begin
        issue           = init_decode_reg;
        issue.valid     = 1'b1;
        issue.pc        = f_pc;
        issue.instr     = f_instr;
        issue.imm       = info.imm;
        issue.rdata1    = rf_rdata1;
        issue.rdata2    = rf_rdata2;
        issue.waddr     = info.waddr;
        issue.wren      = info.wren;
        issue.exception = info.illegal;
        issue.ecause    = info.illegal ? ECAUSE_ILLEGAL_INSTR : ECAUSE_NONE;
        issue.etval     = info.illegal ? f_instr : '0;
    end

    // Hold conditions in priority order: clear, stall, hazard, kill, issue
    always_comb begin
        q_d       = q_q;
        kill_d    = kill_q;
        d_stall   = 1'b0;
        d_jump    = 1'b0;
        d_address = '0;
        if (rst) begin
            q_d    = init_decode_reg;
            kill_d = 1'b0;
        end else if (e_clear) begin
            q_d     = init_decode_reg;
            kill_d  = 1'b0;
            d_stall = 1'b1;
        end else if (e_stall) begin
            d_stall = 1'b1;
        end else if (hazard) begin
            q_d     = init_decode_reg;
            d_stall = 1'b1;
        end else if (kill_q) begin
            q_d    = init_decode_reg;
            kill_d = 1'b0;
        end else begin
            q_d = issue;
            if (info.is_jal) begin
                d_jump    = 1'b1;
                d_address = f_pc + info.imm;
                kill_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= init_decode_reg;
            kill_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            kill_q <= kill_d;
        end
    end

    assign q_bus.q_valid     = q_q.valid;
    assign q_bus.q_pc        = q_q.pc;
    assign q_bus.q_instr     = q_q.instr;
    assign q_bus.q_imm       = q_q.imm;
    assign q_bus.q_rdata1    = q_q.rdata1;
    assign q_bus.q_rdata2    = q_q.rdata2;
    assign q_bus.q_waddr     = q_q.waddr;
    assign q_bus.q_wren      = q_q.wren;
    assign q_bus.q_exception = q_q.exception;
    assign q_bus.q_ecause    = q_q.ecause;
    assign q_bus.q_etval     = q_q.etval;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: each step queues the expected
// execute-side register, a monitor pops and compares it after the clock edge.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_JAL  = 32'h0200_00EF;  // jal  x1,+0x20
    localparam logic [31:0] I_ADD  = 32'h0021_8233;  // add  x4,x3,x2
    localparam logic [31:0] I_ILL  = 32'hFFFF_FFFF;
    localparam logic [31:0] I_CMP  = 32'h0000_0001;  // low bits 01
    localparam logic [31:0] I_SW   = 32'hFE21_AE23;  // sw   x2,-4(x3)
    localparam logic [31:0] I_BEQ  = 32'hFE20_8CE3;  // beq  x1,x2,-8
    localparam logic [31:0] I_LUI  = 32'h1234_52B7;  // lui  x5,0x12345
    localparam logic [31:0] I_NOP  = 32'h0000_0013;  // addi x0,x0,0

    localparam decode_reg_type BUB = '{
        valid: 1'b0, pc: 32'h0, instr: 32'h0000_0013, imm: 32'h0,
        rdata1: 32'h0, rdata2: 32'h0, waddr: 5'd0, wren: 1'b0,
        exception: 1'b0, ecause: 4'd0, etval: 32'h0
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] f_pc = '0;
    logic [31:0] f_instr = '0;
    logic        e_stall = 1'b0;
    logic        e_clear = 1'b0;
    logic        e_load = 1'b0;
    logic [4:0]  e_waddr = '0;
    logic [31:0] rf_rdata1 = '0;
    logic [31:0] rf_rdata2 = '0;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        d_stall;
    logic        d_jump;
    logic [31:0] d_address;

    int checks = 0;
    int errors = 0;

    decode_reg_type sb_q[$];
    string          sb_name[$];

    decode_stage_if q_bus ();

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .e_stall   (e_stall),
        .e_clear   (e_clear),
        .e_load    (e_load),
        .e_waddr   (e_waddr),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .d_stall   (d_stall),
        .d_jump    (d_jump),
        .d_address (d_address),
        .q_bus     (q_bus)
    );

    always #5 clk = ~clk;

    function automatic decode_reg_type mk(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [31:0] imm, input logic [4:0] wa,
                                          input logic we);
        decode_reg_type r;
        r        = BUB;
        r.valid  = 1'b1;
        r.pc     = pc;
        r.instr  = instr;
        r.imm    = imm;
        r.rdata1 = pc + 32'd1;
        r.rdata2 = pc + 32'd2;
        r.waddr  = wa;
        r.wren   = we;
        return r;
    endfunction

    function automatic decode_reg_type mk_ill(input logic [31:0] pc, input logic [31:0] instr);
        decode_reg_type r;
        r           = mk(pc, instr, 32'h0, 5'd0, 1'b0);
        r.exception = 1'b1;
        r.ecause    = 4'd2;
        r.etval     = instr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Drive one fetch word, check the combinational outputs, queue the q expectation
    task automatic step(input string nm, input logic r, input logic clr, input logic stl,
                        input logic ld, input logic [4:0] ew, input logic [31:0] pc,
                        input logic [31:0] instr, input logic xs, input logic xj,
                        input logic [31:0] xa, input decode_reg_type xq);
        @(negedge clk);
        rst       = r;
        e_clear   = clr;
        e_stall   = stl;
        e_load    = ld;
        e_waddr   = ew;
        f_pc      = pc;
        f_instr   = instr;
        rf_rdata1 = pc + 32'd1;
        rf_rdata2 = pc + 32'd2;
        #1;
        chk({nm, ".d_stall"},   32'(d_stall), 32'(xs));
        chk({nm, ".d_jump"},    32'(d_jump),  32'(xj));
        chk({nm, ".d_address"}, d_address,    xa);
        chk({nm, ".raddr1"},    32'(rf_raddr1), 32'(instr[19:15]));
        chk({nm, ".raddr2"},    32'(rf_raddr2), 32'(instr[24:20]));
        sb_q.push_back(xq);
        sb_name.push_back(nm);
    endtask

    // Monitor: the q register is sampled just after every rising edge
    always @(posedge clk) begin
        decode_reg_type act_q;
        decode_reg_type exp_q;
        string          nm;
        #2;
        if (sb_q.size() != 0) begin
            exp_q = sb_q.pop_front();
            nm    = sb_name.pop_front();
            act_q = '{valid: q_bus.q_valid, pc: q_bus.q_pc, instr: q_bus.q_instr,
                      imm: q_bus.q_imm, rdata1: q_bus.q_rdata1, rdata2: q_bus.q_rdata2,
                      waddr: q_bus.q_waddr, wren: q_bus.q_wren,
                      exception: q_bus.q_exception, ecause: q_bus.q_ecause,
                      etval: q_bus.q_etval};
            checks++;
            if (act_q !== exp_q) begin
                errors++;
                $display("FAIL %s.q: got v=%b pc=%h in=%h imm=%h r1=%h r2=%h wa=%0d we=%b ex=%b ec=%0d tv=%h expected v=%b pc=%h in=%h imm=%h r1=%h r2=%h wa=%0d we=%b ex=%b ec=%0d tv=%h",
                         nm, act_q.valid, act_q.pc, act_q.instr, act_q.imm, act_q.rdata1,
                         act_q.rdata2, act_q.waddr, act_q.wren, act_q.exception,
                         act_q.ecause, act_q.etval, exp_q.valid, exp_q.pc, exp_q.instr,
                         exp_q.imm, exp_q.rdata1, exp_q.rdata2, exp_q.waddr, exp_q.wren,
                         exp_q.exception, exp_q.ecause, exp_q.etval);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        decode_reg_type addi_244;
        decode_reg_type jal_304;
        addi_244 = mk(32'h244, I_ADDI, 32'd5, 5'd1, 1'b1);
        jal_304  = mk(32'h304, I_JAL, 32'h20, 5'd1, 1'b1);

        //   name          rst clr stl ld  ew     pc        instr   stall jump addr       expected q
        step("rst0",       1,  0,  1,  0,  5'd0,  32'h200,  I_JAL,  0, 0, 32'h0,   BUB);
        step("rst1",       1,  0,  0,  0,  5'd0,  32'h200,  I_JAL,  0, 0, 32'h0,   BUB);
        step("addi",       0,  0,  0,  0,  5'd0,  32'h100,  I_ADDI, 0, 0, 32'h0,   mk(32'h100, I_ADDI, 32'd5, 5'd1, 1'b1));
        step("jal",        0,  0,  0,  0,  5'd0,  32'h200,  I_JAL,  0, 1, 32'h220, mk(32'h200, I_JAL, 32'h20, 5'd1, 1'b1));
        step("killed",     0,  0,  0,  0,  5'd0,  32'h204,  I_ADDI, 0, 0, 32'h0,   BUB);
        step("target",     0,  0,  0,  0,  5'd0,  32'h220,  I_ADDI, 0, 0, 32'h0,   mk(32'h220, I_ADDI, 32'd5, 5'd1, 1'b1));
        step("loaduse",    0,  0,  0,  1,  5'd3,  32'h224,  I_ADD,  1, 0, 32'h0,   BUB);
        step("add",        0,  0,  0,  0,  5'd0,  32'h224,  I_ADD,  0, 0, 32'h0,   mk(32'h224, I_ADD, 32'h0, 5'd4, 1'b1));
        step("illegal",    0,  0,  0,  0,  5'd0,  32'h228,  I_ILL,  0, 0, 32'h0,   mk_ill(32'h228, I_ILL));
        step("lowbits",    0,  0,  0,  0,  5'd0,  32'h22C,  I_CMP,  0, 0, 32'h0,   mk_ill(32'h22C, I_CMP));
        step("store",      0,  0,  0,  0,  5'd0,  32'h230,  I_SW,   0, 0, 32'h0,   mk(32'h230, I_SW, 32'hFFFF_FFFC, 5'd0, 1'b0));
        step("branch",     0,  0,  0,  0,  5'd0,  32'h234,  I_BEQ,  0, 0, 32'h0,   mk(32'h234, I_BEQ, 32'hFFFF_FFF8, 5'd0, 1'b0));
        step("lui_nohaz",  0,  0,  0,  1,  5'd8,  32'h238,  I_LUI,  0, 0, 32'h0,   mk(32'h238, I_LUI, 32'h1234_5000, 5'd5, 1'b1));
        step("rd0_x0load", 0,  0,  0,  1,  5'd0,  32'h23C,  I_NOP,  0, 0, 32'h0,   mk(32'h23C, I_NOP, 32'h0, 5'd0, 1'b0));
        step("clear_jal",  0,  1,  0,  0,  5'd0,  32'h240,  I_JAL,  1, 0, 32'h0,   BUB);
        step("after_clr",  0,  0,  0,  0,  5'd0,  32'h244,  I_ADDI, 0, 0, 32'h0,   addi_244);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("estall%0d", i),
                           0,  0,  1,  0,  5'd0,  32'h248,  I_JAL,  1, 0, 32'h0,   addi_244);
        end
        step("stall_rel",  0,  0,  0,  0,  5'd0,  32'h248,  I_JAL,  0, 1, 32'h268, mk(32'h248, I_JAL, 32'h20, 5'd1, 1'b1));
        step("rst_kill",   1,  0,  0,  0,  5'd0,  32'h24C,  I_ADDI, 0, 0, 32'h0,   BUB);
        step("post_rst1",  0,  0,  0,  0,  5'd0,  32'h300,  I_ADDI, 0, 0, 32'h0,   mk(32'h300, I_ADDI, 32'd5, 5'd1, 1'b1));
        step("jal2",       0,  0,  0,  0,  5'd0,  32'h304,  I_JAL,  0, 1, 32'h324, jal_304);
        step("stall_kill", 0,  0,  1,  0,  5'd0,  32'h308,  I_ADDI, 1, 0, 32'h0,   jal_304);
        step("rst_stall",  1,  0,  1,  0,  5'd0,  32'h308,  I_ADDI, 0, 0, 32'h0,   BUB);
        step("post_rst2",  0,  0,  0,  0,  5'd0,  32'h400,  I_ADDI, 0, 0, 32'h0,   mk(32'h400, I_ADDI, 32'd5, 5'd1, 1'b1));

        @(negedge clk);
        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data/address and 5-bit register indices.
REQ-002 The block SHALL have these ports, one per line:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  f_pc  in  32  PC of the instruction word presented by fetch
  f_instr  in  32  instruction word from fetch
  e_stall  in  1  execute stage is holding its input
  e_clear  in  1  execute stage flush (trap or branch redirect)
  e_load  in  1  instruction currently in execute is a load
  e_waddr  in  5  destination register of the instruction in execute
  rf_rdata1  in  32  register file read data, port 1
  rf_rdata2  in  32  register file read data, port 2
  rf_raddr1  out  5  register file read address, port 1 (rs1)
  rf_raddr2  out  5  register file read address, port 2 (rs2)
  d_stall  out  1  stall request to fetch
  d_jump  out  1  redirect request to fetch
  d_address  out  32  redirect target
  q_valid  out  1  execute-side slot holds a real instruction
  q_pc, q_instr, q_imm, q_rdata1, q_rdata2  out  32 each  registered operands to execute
  q_waddr  out  5  destination register
  q_wren  out  1  writeback enable
  q_exception  out  1  illegal instruction flag
  q_ecause  out  4  exception cause
  q_etval  out  32  exception value

Function
REQ-003 The block SHALL decode RV32I base opcodes only; every other opcode, and any encoding with the low two bits not equal to 11b, SHALL be illegal.
REQ-004 For an illegal instruction, the block SHALL set q_exception=1, q_ecause=2 and q_etval=instr.
REQ-005 Immediates SHALL be sign-extended to 32 bits per the I/S/B/U/J formats; q_imm SHALL be 0 for R-type instructions.
REQ-006 q_wren SHALL be 0 when rd=0, and for branch, store, fence and illegal instructions.
REQ-007 rf_raddr1 and rf_raddr2 SHALL be driven combinationally from f_instr[19:15] and f_instr[24:20].
REQ-008 The output register SHALL capture the decoded f_instr, the operands and f_pc on each clock in which no hold condition applies, giving 1-cycle latency.
REQ-009 On JAL, the block SHALL assert d_jump=1 and d_address=f_pc+J-imm combinationally in the same cycle; JAL SHALL still pass downstream with q_wren set for the link.
REQ-010 The block SHALL provide a one-bit kill flag, set on the cycle JAL is accepted; the next incoming word SHALL then be squashed as a bubble (q_valid=0) and the flag cleared.
REQ-011 Load-use hazard: if e_load=1, e_waddr!=0, and e_waddr equals a source register actually used by the decoded format, the block SHALL assert d_stall=1, insert a bubble into q, and keep f_instr for re-decode on the next cycle.
REQ-012 The block SHALL assert d_stall=1 whenever e_stall=1, and SHALL hold the q register unchanged while e_stall=1.
REQ-013 e_clear=1 SHALL force q_valid=0, clear the kill flag, suppress d_jump, and assert d_stall=1.
REQ-014 Priority SHALL be e_clear > e_stall > load-use hazard > kill > normal decode.
REQ-015 d_jump SHALL NOT be asserted while d_stall=1, and a JAL stalled by a hazard SHALL redirect only on its accepting cycle.
REQ-016 A bubble SHALL have q_valid=0, q_wren=0, q_exception=0 and q_instr=0x00000013 (NOP).

Reset
REQ-017 On rst, the block SHALL set q_valid=0, q_wren=0, q_exception=0, q_ecause=0, q_etval=0, q_pc=0, q_instr=0x00000013, all other q fields to 0, and the kill flag to 0.
REQ-018 d_stall, d_jump and d_address SHALL be 0 while rst=1.
REQ-019 A reset asserted mid-stall or mid-kill SHALL discard that state with no carry-over.

Structure
REQ-020 decode_reg_type, init_decode_reg, the opcode constants and the ecause constants SHALL live in the shared wires package.
REQ-021 A combinational sub-module, decoder, SHALL produce the immediate, the format/use-rs flags, waddr, wren and illegal from the instruction word; decode_stage SHALL hold all state.

Verification
REQ-022 addi x1,x0,5 at pc 0x100 -> next cycle: q_valid=1, q_imm=5, q_waddr=1, q_wren=1, q_pc=0x100.
REQ-023 jal x1,+0x20 at pc 0x200 -> same cycle d_jump=1, d_address=0x220; the following word yields q_valid=0.
REQ-024 e_load=1, e_waddr=3, decode add x4,x3,x2 -> d_stall=1 for one cycle, one bubble, then add is issued.
REQ-025 Instruction 0xFFFFFFFF -> q_exception=1, q_ecause=2, q_etval=0xFFFFFFFF, q_wren=0.
REQ-026 e_clear=1 coincident with a JAL -> d_jump=0, q_valid=0, kill flag=0.
REQ-027 e_stall=1 held for 3 cycles -> q unchanged and d_stall=1 throughout; normal decode resumes on release.
